// File: rtl/spine_egress_buffer.sv
// Egress buffer for one router spine output: first-word-fall-through FIFO with a valid/ready
// link side, head-flit destination extraction, occupancy status and a saturating drop counter.
module spine_egress_buffer #(
   parameter int DWIDTH       = 16,
   parameter int DEPTH        = 8,
   parameter int AFULL_THRESH = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DWIDTH-1:0]          in_data,
   input  logic                       in_valid,
   output logic [DWIDTH-1:0]          out_data,
   output logic                       out_valid,
   output logic [5:0]                 out_dest_addr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic [15:0]                drop_count,
   input  logic                       drop_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DWIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW-1:0]     rd_ptr_inc_s;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_next_s;
   logic              full_r;
   logic              empty_r;
   logic              afull_r;
   logic              out_valid_r;
   logic [DWIDTH-1:0] out_data_r;
   logic [DWIDTH-1:0] head_next_s;
   logic [15:0]       drop_count_r;
   logic [15:0]       drop_next_s;
   logic              push_s;
   logic              pop_s;
   logic              drop_s;

   // Handshake decode, next occupancy, next head flit and next drop count
   always_comb begin
      pop_s        = out_valid_r & out_ready;
      push_s       = in_valid & (~full_r | pop_s);
      drop_s       = in_valid & full_r & ~pop_s;
      rd_ptr_inc_s = rd_ptr_r + AW'(1);

      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase

      // The head is registered: it comes from memory, or straight from in_data when the
      // incoming flit becomes the only entry.
      head_next_s = out_data_r;
      if (count_next_s == CW'(0)) begin
         head_next_s = {DWIDTH{1'b0}};
      end else if (pop_s) begin
         head_next_s = (count_r == CW'(1)) ? in_data : mem_r[rd_ptr_inc_s];
      end else if (count_r == CW'(0)) begin
         head_next_s = in_data;
      end else begin
         head_next_s = out_data_r;
      end

      drop_next_s = drop_count_r;
      if (drop_clr) begin
         drop_next_s = drop_s ? 16'h0001 : 16'h0000;
      end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
         drop_next_s = drop_count_r + 16'h0001;
      end else begin
         drop_next_s = drop_count_r;
      end
   end

   // Flit storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointers, occupancy, status flags, head flit and drop counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         count_r      <= {CW{1'b0}};
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
         afull_r      <= 1'b0;
         out_valid_r  <= 1'b0;
         out_data_r   <= {DWIDTH{1'b0}};
         drop_count_r <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_inc_s;
         end
         count_r      <= count_next_s;
         full_r       <= (count_next_s == CW'(DEPTH));
         empty_r      <= (count_next_s == CW'(0));
         afull_r      <= (count_next_s >= CW'(AFULL_THRESH));
         out_valid_r  <= (count_next_s != CW'(0));
         out_data_r   <= head_next_s;
         drop_count_r <= drop_next_s;
      end
   end

   assign out_data      = out_data_r;
   assign out_valid     = out_valid_r;
   assign out_dest_addr = out_data_r[DWIDTH-1 -: 6];
   assign fifo_count    = count_r;
   assign full          = full_r;
   assign empty         = empty_r;
   assign almost_full   = afull_r;
   assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_spine_egress_buffer.sv
// Scoreboard bench for spine_egress_buffer: directed stimulus queues expected flits,
// a negedge monitor checks every accepted output flit; status is checked directly.
module tb_spine_egress_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic [5:0]  out_dest_addr;
   logic        out_ready;
   logic [3:0]  fifo_count;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [15:0] drop_count;
   logic        drop_clr;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_q[$];

   spine_egress_buffer #(.DWIDTH(16), .DEPTH(8), .AFULL_THRESH(6)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_dest_addr(out_dest_addr),
      .out_ready(out_ready), .fifo_count(fifo_count), .full(full), .empty(empty),
      .almost_full(almost_full), .drop_count(drop_count), .drop_clr(drop_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted flit must match the scoreboard head
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_flit: got %0h, expected none", out_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (out_data !== e || out_dest_addr !== e[15:10]) begin
               fails++;
               $display("FAIL flit_order: got %0h/%0h, expected %0h/%0h",
                        out_data, out_dest_addr, e, e[15:10]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; in_data = 16'h0000; in_valid = 1'b0; out_ready = 1'b0; drop_clr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_dest", out_dest_addr, 6'h00);
      chk("rst_count", fifo_count, 4'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_afull", almost_full, 1'b0);
      chk("rst_drop", drop_count, 16'h0000);

      // Single flit with hold
      in_valid = 1'b1; in_data = 16'hA5C3; exp_q.push_back(16'hA5C3);
      tick();
      in_valid = 1'b0; in_data = 16'h0000;
      chk("single_valid", out_valid, 1'b1);
      chk("single_data", out_data, 16'hA5C3);
      chk("single_dest", out_dest_addr, 6'h29);
      chk("single_count", fifo_count, 4'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_data", out_data, 16'hA5C3);
         chk("hold_dest", out_dest_addr, 6'h29);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop_empty", empty, 1'b1);
      chk("pop_valid", out_valid, 1'b0);
      chk("pop_data", out_data, 16'h0000);

      // Fill and overflow
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_data = 16'(i);
         if (i <= 8) exp_q.push_back(16'(i));
         tick();
         chk("fill_count", fifo_count, (i < 8) ? i : 8);
         chk("fill_afull", almost_full, (i >= 6) ? 1'b1 : 1'b0);
         chk("fill_full", full, (i >= 8) ? 1'b1 : 1'b0);
      end
      in_valid = 1'b0;
      chk("overflow_drops", drop_count, 16'd2);

      // Push and pop together while full: no drop
      in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; exp_q.push_back(16'hBEEF);
      tick();
      in_valid = 1'b0;
      chk("fullpp_count", fifo_count, 4'd8);
      chk("fullpp_drop", drop_count, 16'd2);
      for (int i = 0; i < 8; i++) tick();
      out_ready = 1'b0;
      chk("drain_empty", empty, 1'b1);
      chk("drain_sb", exp_q.size(), 0);

      // drop_clr alone
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      chk("clr_alone", drop_count, 16'h0000);

      // Pointer wrap with continuous push/pop
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_data = 16'h1000 + 16'(i); exp_q.push_back(16'h1000 + 16'(i));
         tick();
         chk("wrap_count", fifo_count, 4'd1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("wrap_empty", empty, 1'b1);
      chk("wrap_drop", drop_count, 16'h0000);
      chk("wrap_sb", exp_q.size(), 0);

      // Saturation of the drop counter
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 16'h2000 + 16'(i); exp_q.push_back(16'h2000 + 16'(i));
         tick();
      end
      in_data = 16'hDEAD;
      for (int i = 0; i < 65535; i++) tick();
      chk("sat_reach", drop_count, 16'hFFFF);
      for (int i = 0; i < 3; i++) tick();
      chk("sat_hold", drop_count, 16'hFFFF);
      drop_clr = 1'b1;
      tick();
      chk("clr_with_drop", drop_count, 16'h0001);
      in_valid = 1'b0;
      tick();
      drop_clr = 1'b0;
      chk("clr_alone2", drop_count, 16'h0000);
      chk("sat_count", fifo_count, 4'd8);

      // Reset mid-operation with 5 flits buffered
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      out_ready = 1'b0;
      chk("pre_rst_count", fifo_count, 4'd5);
      reset = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
      exp_q.delete();
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_count", fifo_count, 4'd0);
      chk("mid_rst_drop", drop_count, 16'h0000);
      in_valid = 1'b1; in_data = 16'hC0DE; exp_q.push_back(16'hC0DE);
      tick();
      in_valid = 1'b0;
      chk("post_rst_head", out_data, 16'hC0DE);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_rst_empty", empty, 1'b1);
      chk("final_sb", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
